// File: rtl/serial_adder_nbit.sv
// ============================================================================
// serial_adder_nbit
//
// Bit-serial ripple adder. It uses one full-adder cell and a registered carry,
// and processes one bit per clock, LSB first. A start/busy/done handshake
// frames each operation. The final Sum/Cout are held in output registers until
// the next operation completes.
//
// Parameters:
//   WIDTH  operand and sum width in bits (WIDTH >= 1)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous, active-low reset
//   start  request; sampled only in IDLE or DONE
//   A, B   operands; captured when start is accepted
//   Cin    carry-in; captured when start is accepted
//   busy   high while the adder is in RUN
//   done   one-cycle pulse; Sum/Cout update in the same cycle
//   Sum    registered result, A+B+Cin mod 2^WIDTH
//   Cout   registered carry-out of the MSB
//   Ovf    (only when SERIAL_ADD_OVF_EN is defined) registered two's-complement
//          overflow, equal to carry into the MSB XOR carry out of the MSB
//
// Build option: define SERIAL_ADD_OVF_EN to add the Ovf output.
// ============================================================================
module serial_adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             Cout,
    output logic             Ovf
`else
    output logic             Cout
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b, sh_sum, sum_nxt;
    logic             carry, carry_nxt, bit_s;
    logic [CW-1:0]    cnt;
    logic             load, last;

    // The full-adder cell works on the current LSBs and the registered carry.
    assign bit_s     = sh_a[0] ^ sh_b[0] ^ carry;
    assign carry_nxt = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));

    // The new sum bit enters at the MSB, so after WIDTH shifts the first bit
    // computed sits at bit 0. A 1-bit adder has nothing to shift down.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_nxt = bit_s;
        end else begin : g_wn
            assign sum_nxt = {bit_s, sh_sum[WIDTH-1:1]};
        end
    endgenerate

    assign last = (cnt == CW'(WIDTH - 1));
    assign load = start && ((state == IDLE) || (state == DONE));

    // NOTE: state and data registers use non-blocking assignments, so every
    // register updates from values sampled before the same clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the shift registers are reset together with the control state.
    // This leaves no X in the pipeline after reset. Nothing here is a memory
    // array, so resetting them is cheap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a   <= '0;
            sh_b   <= '0;
            sh_sum <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Sum    <= '0;
            Cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            Ovf    <= 1'b0;
`endif
        end else if (load) begin
            sh_a  <= A;
            sh_b  <= B;
            carry <= Cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            sh_a   <= sh_a >> 1;
            sh_b   <= sh_b >> 1;
            sh_sum <= sum_nxt;
            carry  <= carry_nxt;
            cnt    <= cnt + CW'(1);
            if (last) begin
                Sum  <= sum_nxt;
                Cout <= carry_nxt;
`ifdef SERIAL_ADD_OVF_EN
                // On the last bit the registered carry is the carry into the MSB.
                Ovf  <= carry ^ carry_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// ============================================================================
// tb_serial_adder_nbit
//
// Scoreboard bench for serial_adder_nbit. It builds 8-, 4- and 1-bit
// instances. Each accepted operation pushes its expected {Cout,Sum}, Ovf and
// done cycle. The monitors pop an entry on every done pulse and compare it.
// ============================================================================
module tb_serial_adder_nbit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [8:0] res;
        logic       ovf;
        int         due;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t q1[$];

    // Reference: plain integer addition plus the sign-rule overflow.
    // Start is assumed driven before edge cyc+1, so done is due w edges later.
    function automatic exp_t mk(input int w, input logic [7:0] a, input logic [7:0] b, input logic ci);
        exp_t e;
        logic [8:0] t;
        t     = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        e.res = t;
        e.ovf = (a[w-1] == b[w-1]) && (t[w-1] != a[w-1]);
        e.due = cyc + 1 + w;
        return e;
    endfunction

    // ---------------- DUT instances ----------------
    logic       st8 = 0, ci8 = 0, busy8, done8, co8, ovf8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       st4 = 0, ci4 = 0, busy4, done4, co4, ovf4;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       st1 = 0, ci1 = 0, busy1, done1, co1, ovf1;
    logic [0:0] a1 = '0, b1 = '0, sum1;

    serial_adder_nbit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .A(a8), .B(b8), .Cin(ci8),
        .busy(busy8), .done(done8), .Sum(sum8),
`ifdef SERIAL_ADD_OVF_EN
        .Ovf(ovf8),
`endif
        .Cout(co8));

    serial_adder_nbit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .A(a4), .B(b4), .Cin(ci4),
        .busy(busy4), .done(done4), .Sum(sum4),
`ifdef SERIAL_ADD_OVF_EN
        .Ovf(ovf4),
`endif
        .Cout(co4));

    serial_adder_nbit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .A(a1), .B(b1), .Cin(ci1),
        .busy(busy1), .done(done1), .Sum(sum1),
`ifdef SERIAL_ADD_OVF_EN
        .Ovf(ovf1),
`endif
        .Cout(co1));

`ifndef SERIAL_ADD_OVF_EN
    assign ovf8 = 1'b0;
    assign ovf4 = 1'b0;
    assign ovf1 = 1'b0;
`endif

    // ---------------- monitors ----------------
    int dn8 = 0;

    always @(negedge clk) begin
        if (rst_n && done8) begin
            exp_t e;
            dn8 <= dn8 + 1;
            if (q8.size() == 0) begin
                check("done8_unexpected", 1, 0);
            end else begin
                e = q8.pop_front();
                check("sum8", {co8, sum8}, e.res);
                check("lat8", cyc, e.due);
`ifdef SERIAL_ADD_OVF_EN
                check("ovf8", ovf8, e.ovf);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done4) begin
            exp_t e;
            if (q4.size() == 0) begin
                check("done4_unexpected", 1, 0);
            end else begin
                e = q4.pop_front();
                check("sum4", {co4, sum4}, e.res);
                check("lat4", cyc, e.due);
`ifdef SERIAL_ADD_OVF_EN
                check("ovf4", ovf4, e.ovf);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done1) begin
            exp_t e;
            if (q1.size() == 0) begin
                check("done1_unexpected", 1, 0);
            end else begin
                e = q1.pop_front();
                check("sum1", {co1, sum1}, e.res);
                check("lat1", cyc, e.due);
`ifdef SERIAL_ADD_OVF_EN
                check("ovf1", ovf1, e.ovf);
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci, input bit push);
        a8  = a;
        b8  = b;
        ci8 = ci;
        st8 = 1'b1;
        if (push) q8.push_back(mk(8, a, b, ci));
    endtask

    task automatic pulse8(input logic [7:0] a, input logic [7:0] b, input logic ci, input bit push);
        @(posedge clk); #1;
        drive8(a, b, ci, push);
        @(posedge clk); #1;
        st8 = 1'b0;
    endtask

    task automatic pulse4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        @(posedge clk); #1;
        a4 = a; b4 = b; ci4 = ci; st4 = 1'b1;
        q4.push_back(mk(4, {4'd0, a}, {4'd0, b}, ci));
        @(posedge clk); #1;
        st4 = 1'b0;
    endtask

    task automatic pulse1(input logic a, input logic b, input logic ci);
        @(posedge clk); #1;
        a1 = a; b1 = b; ci1 = ci; st1 = 1'b1;
        q1.push_back(mk(1, {7'd0, a}, {7'd0, b}, ci));
        @(posedge clk); #1;
        st1 = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((q8.size() + q4.size() + q1.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", q8.size() + q4.size() + q1.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int nb;
        int dn0;
        int n;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_res8", {co8, sum8}, 0);
        check("rst_busy4", busy4, 0);
        check("rst_busy1", busy1, 0);
        rst_n = 1'b1;

        // FF + 01: busy for exactly 8 cycles, wraps to 00 with carry out.
        pulse8(8'hFF, 8'h01, 1'b0, 1'b1);
        nb = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy8) nb++;
        end
        check("busy_cycles", nb, 8);
        wait_drain(5);
        check("hold_ff01", {co8, sum8}, 9'h100);

        // 00 + 00 + 1 with start held through RUN and operands changing.
        dn0 = dn8;
        @(posedge clk); #1;
        drive8(8'h00, 8'h00, 1'b1, 1'b1);
        repeat (9) begin
            @(posedge clk); #1;
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            ci8 = 1'($urandom);
        end
        st8 = 1'b0;
        repeat (12) @(negedge clk);
        check("one_done", dn8 - dn0, 1);
        check("hold_0001", {co8, sum8}, 9'h001);
        wait_drain(2);

        // Back-to-back: a new start in DONE goes straight to RUN.
        pulse8(8'h0F, 8'h01, 1'b0, 1'b1);
        n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_wait", done8, 1);
        drive8(8'h12, 8'h34, 1'b0, 1'b1);
        @(posedge clk); #1;
        st8 = 1'b0;
        @(negedge clk);
        check("b2b_busy", busy8, 1);
        check("b2b_hold_a", {co8, sum8}, 9'h010);
        repeat (4) @(negedge clk);
        check("b2b_hold_b", {co8, sum8}, 9'h010);
        wait_drain(10);
        check("b2b_res", {co8, sum8}, 9'h046);

        // Reset during RUN discards the operation immediately.
        pulse8(8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_done", done8, 0);
        check("mid_rst_res", {co8, sum8}, 0);
        dn0 = dn8;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("mid_rst_nodone", dn8 - dn0, 0);
        check("mid_rst_idle", busy8, 0);
        pulse8(8'hAA, 8'h55, 1'b1, 1'b1);
        wait_drain(15);

`ifdef SERIAL_ADD_OVF_EN
        pulse8(8'h7F, 8'h01, 1'b0, 1'b1);
        wait_drain(15);
        pulse8(8'h80, 8'h80, 1'b0, 1'b1);
        wait_drain(15);
        pulse8(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_drain(15);
`endif

        // Exhaustive sweeps of the narrow instances.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    pulse4(4'(a), 4'(b), 1'(c));
                    wait_drain(10);
                end
            end
        end
        for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < 2; c++) begin
                    pulse1(1'(a), 1'(b), 1'(c));
                    wait_drain(6);
                end
            end
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
